// File: rtl/dmem_responder.sv
// Purpose : MEM-stage data-port responder. It takes one load or store at a time over
//           valid/ready and services it from an internal word array after LATENCY
//           cycles. It returns a one-cycle response and stalls the pipeline while busy.
// Ports   : clk/reset (sync, active-high); req_valid/req_ready/req_write/req_addr/req_wdata
//           request side; resp_valid/resp_rdata/resp_err response side; stall to pipeline.
module dmem_responder #(
    parameter int DEPTH_WORDS = 16384,
    parameter int LATENCY     = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        stall
);
    localparam int AW = $clog2(DEPTH_WORDS);
    // The counter only ever holds LATENCY-1 down to 1.
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic            wr_q;
    logic [31:0]     addr_q;
    logic [31:0]     wdata_q;
    logic            req_ready_q;
    logic            resp_valid_q;
    logic [31:0]     resp_rdata_q;
    logic            resp_err_q;

    logic [31:0]     mem [DEPTH_WORDS];

    // Access-edge selection. Normally the access uses the latched request fields
    // on the last BUSY edge. With LATENCY==1 there is no BUSY state, so the access
    // happens on the handshake edge itself and must use the live request inputs.
    logic            acc_fire;
    logic            acc_write;
    logic [31:0]     acc_addr;
    logic [31:0]     acc_wdata;
    logic            acc_err;
    logic [AW-1:0]   acc_idx;

    always_comb begin
        acc_fire  = 1'b0;
        acc_write = wr_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        if (state_q == IDLE && LATENCY == 1) begin
            acc_fire  = req_valid;
            acc_write = req_write;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
        end else if (state_q == BUSY && cnt_q == CW'(1)) begin
            acc_fire  = 1'b1;
        end
    end

    // Widen to 64 bits so 4*DEPTH_WORDS cannot overflow for large arrays.
    assign acc_err = (acc_addr[1:0] != 2'b00) ||
                     ({32'd0, acc_addr} >= (64'(DEPTH_WORDS) * 64'd4));
    assign acc_idx = acc_addr[AW+1:2];

    // The array has no reset. A reset on the access edge suppresses the write,
    // so an abandoned request never modifies memory.
    always_ff @(posedge clk) begin
        if (!reset && acc_fire && acc_write && !acc_err) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;

            // Response data/err change only on an access edge and hold otherwise.
            if (acc_fire) begin
                resp_err_q   <= acc_err;
                resp_rdata_q <= (acc_write || acc_err) ? 32'd0 : mem[acc_idx];
            end

            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        wr_q        <= req_write;
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        cnt_q       <= CW'(LATENCY - 1);
                        req_ready_q <= 1'b0;
                        if (LATENCY == 1) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                        end else begin
                            state_q <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q      <= RESP;
                        resp_valid_q <= 1'b1;
                    end
                end
                RESP: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    // Low in RESP so the pipeline advances in the cycle the data is presented.
    assign stall      = ((state_q == IDLE) && req_valid) || (state_q == BUSY);

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
    localparam int DEPTH = 16384;
    localparam int LAT   = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req_valid, req_write;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, resp_valid, resp_err, stall;
    logic [31:0] resp_rdata;

    logic        r1_valid, r1_write;
    logic [31:0] r1_addr, r1_wdata;
    logic        r1_ready, r1_resp_valid, r1_err, r1_stall;
    logic [31:0] r1_rdata;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .stall(stall)
    );

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) dut1 (
        .clk(clk), .reset(reset),
        .req_valid(r1_valid), .req_ready(r1_ready), .req_write(r1_write),
        .req_addr(r1_addr), .req_wdata(r1_wdata),
        .resp_valid(r1_resp_valid), .resp_rdata(r1_rdata), .resp_err(r1_err),
        .stall(r1_stall)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int resp_cnt = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;
    exp_t sb[$];
    logic [31:0] model [int];

    // Scoreboard consumer: every resp_valid pops one expectation.
    exp_t e;
    always @(negedge clk) begin
        if (resp_valid === 1'b1) begin
            resp_cnt++;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL resp_unexpected: got resp at cycle %0d, required none", cyc);
            end else begin
                e = sb.pop_front();
                if (resp_rdata !== e.rdata || resp_err !== e.err || cyc !== e.cyc) begin
                    bad++;
                    $display("FAIL resp: rdata=%h err=%b cycle=%0d, required rdata=%h err=%b cycle=%0d",
                             resp_rdata, resp_err, cyc, e.rdata, e.err, e.cyc);
                end
            end
        end
    end

    // Drives one request from a posedge+1 phase, waits for the handshake and pushes
    // the expected response. Returns in the posedge+1 phase of the following cycle.
    task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d,
                         input bit keep, output int hs_cyc, output logic st_hs);
        int guard = 0;
        logic er;
        int idx;
        exp_t x;
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
        @(negedge clk);
        while (req_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) begin
            total++; bad++;
            $display("FAIL handshake_timeout: req_ready=%b, required 1", req_ready);
        end
        hs_cyc = cyc;
        st_hs  = stall;
        er  = (a[1:0] != 2'b00) || (a >= 32'(4 * DEPTH));
        idx = int'(a[15:2]);
        x.err = er;
        x.cyc = cyc + LAT;
        if (er)      x.rdata = 32'd0;
        else if (wr) begin x.rdata = 32'd0; model[idx] = d; end
        else         x.rdata = model[idx];
        sb.push_back(x);
        @(posedge clk); #1;
        if (!keep) req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (sb.size() != 0 && guard < 30) begin
            @(negedge clk);
            guard++;
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL resp_timeout: pending=%0d, required 0", sb.size());
            sb.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        r1_valid = 1'b0; r1_write = 1'b0; r1_addr = '0; r1_wdata = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        total += 6;
        if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b, required 1", req_ready); end
        if (resp_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b, required 0", resp_valid); end
        if (resp_rdata !== 32'd0) begin bad++; $display("FAIL rst_rdata: got %h, required 0", resp_rdata); end
        if (resp_err !== 1'b0) begin bad++; $display("FAIL rst_err: got %b, required 0", resp_err); end
        if (stall !== 1'b0) begin bad++; $display("FAIL rst_stall: got %b, required 0", stall); end
        if (r1_ready !== 1'b1) begin bad++; $display("FAIL rst_ready_lat1: got %b, required 1", r1_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_store_load();
        int hs; logic st;
        issue(1'b1, 32'h40, 32'hDEADBEEF, 1'b0, hs, st);
        total++;
        if (st !== 1'b1) begin bad++; $display("FAIL stall_hs: got %b, required 1", st); end
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            total += 2;
            if (stall !== 1'b1) begin bad++; $display("FAIL stall_busy%0d: got %b, required 1", i, stall); end
            if (req_ready !== 1'b0) begin bad++; $display("FAIL ready_busy%0d: got %b, required 0", i, req_ready); end
        end
        @(negedge clk);
        total++;
        if (stall !== 1'b0) begin bad++; $display("FAIL stall_resp: got %b, required 0", stall); end
        wait_idle();
        issue(1'b0, 32'h40, 32'h0, 1'b0, hs, st);
        wait_idle();
    endtask

    task automatic test_errors();
        int hs; logic st;
        issue(1'b0, 32'h42, 32'h0, 1'b0, hs, st);
        wait_idle();
        issue(1'b0, 32'(4 * DEPTH), 32'h0, 1'b0, hs, st);
        wait_idle();
        // err result holds after RESP until the next access
        @(negedge clk);
        total++;
        if (resp_err !== 1'b1) begin bad++; $display("FAIL err_hold: got %b, required 1", resp_err); end
        @(posedge clk); #1;
        issue(1'b1, 32'h42, 32'h11111111, 1'b0, hs, st);
        wait_idle();
        issue(1'b1, 32'(4 * DEPTH) + 32'h40, 32'h22222222, 1'b0, hs, st);
        wait_idle();
        issue(1'b0, 32'h40, 32'h0, 1'b0, hs, st);
        wait_idle();
    endtask

    task automatic test_back_to_back();
        int hs1, hs2, c0; logic st;
        issue(1'b1, 32'h80, 32'hAAAA5555, 1'b0, hs1, st);
        wait_idle();
        c0 = resp_cnt;
        issue(1'b0, 32'h40, 32'h0, 1'b1, hs1, st);
        issue(1'b0, 32'h80, 32'h0, 1'b0, hs2, st);
        total++;
        if (hs2 - hs1 != LAT + 1) begin bad++; $display("FAIL b2b_gap: got %0d, required %0d", hs2 - hs1, LAT + 1); end
        wait_idle();
        repeat (4) @(posedge clk); #1;
        total++;
        if (resp_cnt - c0 != 2) begin bad++; $display("FAIL b2b_count: got %0d, required 2", resp_cnt - c0); end
    endtask

    task automatic test_reset_busy();
        int c0, hs; logic st;
        c0 = resp_cnt;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h80; req_wdata = 32'h12345678;
        @(negedge clk);
        total++;
        if (req_ready !== 1'b1) begin bad++; $display("FAIL rb_ready: got %b, required 1", req_ready); end
        @(posedge clk); #1 req_valid = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        total += 5;
        if (req_ready !== 1'b1) begin bad++; $display("FAIL rb_ready_after: got %b, required 1", req_ready); end
        if (resp_valid !== 1'b0) begin bad++; $display("FAIL rb_valid_after: got %b, required 0", resp_valid); end
        if (resp_rdata !== 32'd0) begin bad++; $display("FAIL rb_rdata_after: got %h, required 0", resp_rdata); end
        if (resp_err !== 1'b0) begin bad++; $display("FAIL rb_err_after: got %b, required 0", resp_err); end
        if (stall !== 1'b0) begin bad++; $display("FAIL rb_stall_after: got %b, required 0", stall); end
        repeat (8) @(posedge clk); #1;
        total++;
        if (resp_cnt != c0) begin bad++; $display("FAIL rb_no_resp: got %0d responses, required 0", resp_cnt - c0); end
        issue(1'b0, 32'h80, 32'h0, 1'b0, hs, st);
        wait_idle();
    endtask

    task automatic test_latched_fields();
        int hs; logic st;
        issue(1'b1, 32'hC0, 32'h5A5A5A5A, 1'b0, hs, st);
        req_addr = 32'h40; req_wdata = 32'hFFFFFFFF; req_write = 1'b0;
        wait_idle();
        issue(1'b0, 32'hC0, 32'h0, 1'b0, hs, st);
        req_addr = 32'h40; req_write = 1'b1;
        wait_idle();
        issue(1'b0, 32'h40, 32'h0, 1'b0, hs, st);
        wait_idle();
    endtask

    task automatic test_latency1();
        r1_valid = 1'b1; r1_write = 1'b1; r1_addr = 32'h10; r1_wdata = 32'hCAFEF00D;
        @(negedge clk);
        total += 2;
        if (r1_ready !== 1'b1) begin bad++; $display("FAIL l1_ready: got %b, required 1", r1_ready); end
        if (r1_stall !== 1'b1) begin bad++; $display("FAIL l1_stall_hs: got %b, required 1", r1_stall); end
        @(posedge clk); #1 r1_valid = 1'b0;
        @(negedge clk);
        total += 3;
        if (r1_resp_valid !== 1'b1) begin bad++; $display("FAIL l1_st_valid: got %b, required 1", r1_resp_valid); end
        if (r1_stall !== 1'b0) begin bad++; $display("FAIL l1_st_stall: got %b, required 0", r1_stall); end
        if (r1_err !== 1'b0) begin bad++; $display("FAIL l1_st_err: got %b, required 0", r1_err); end
        @(posedge clk); #1;
        r1_valid = 1'b1; r1_write = 1'b0; r1_addr = 32'h10; r1_wdata = 32'h0;
        @(negedge clk);
        total += 2;
        if (r1_ready !== 1'b1) begin bad++; $display("FAIL l1_ld_ready: got %b, required 1", r1_ready); end
        if (r1_stall !== 1'b1) begin bad++; $display("FAIL l1_ld_stall: got %b, required 1", r1_stall); end
        @(posedge clk); #1 r1_valid = 1'b0;
        @(negedge clk);
        total += 3;
        if (r1_resp_valid !== 1'b1) begin bad++; $display("FAIL l1_ld_valid: got %b, required 1", r1_resp_valid); end
        if (r1_rdata !== 32'hCAFEF00D) begin bad++; $display("FAIL l1_ld_rdata: got %h, required cafef00d", r1_rdata); end
        if (r1_stall !== 1'b0) begin bad++; $display("FAIL l1_ld_stall_resp: got %b, required 0", r1_stall); end
        @(negedge clk);
        total++;
        if (r1_resp_valid !== 1'b0) begin bad++; $display("FAIL l1_one_pulse: got %b, required 0", r1_resp_valid); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_errors();
        test_back_to_back();
        test_reset_busy();
        test_latched_fields();
        test_latency1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
